// File: rtl/mdu_stall_source.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// An arithmetic op latches its operands, holds busy high for a fixed number
// of cycles so the hazard unit can stall the pipeline, then writes HI/LO.
// MTHI/MTLO write directly from A while idle; requests made while busy are dropped.
module mdu_stall_source #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;

  // Datapath signals derived from the latched operands only.
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [63:0]        a_ext;
  logic [63:0]        b_ext;
  logic [63:0]        prod;
  logic [31:0]        dividend;
  logic [31:0]        divisor;
  logic [31:0]        uquot;
  logic [31:0]        urem;
  logic [31:0]        quot;
  logic [31:0]        rem;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_we;

  assign signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign a_neg     = signed_op && a_q[31];
  assign b_neg     = signed_op && b_q[31];

  // Sign-extend for signed multiply so the low 64 bits of the product are exact.
  assign a_ext = {{32{a_neg}}, a_q};
  assign b_ext = {{32{b_neg}}, b_q};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out naturally as
  // quotient 0x80000000, remainder 0, since its magnitude is itself.
  assign dividend = a_neg ? (~a_q + 32'd1) : a_q;
  assign divisor  = (b_q == 32'd0) ? 32'd1 : (b_neg ? (~b_q + 32'd1) : b_q);
  assign uquot    = dividend / divisor;
  assign urem     = dividend % divisor;
  assign quot     = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
  assign rem      = a_neg ? (~urem + 32'd1) : urem;

  // Select the result to commit when the busy window closes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    res_hi = '0;
    res_lo = '0;
    res_we = 1'b0;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_we = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi = rem;
        res_lo = quot;
        res_we = (b_q != 32'd0);
      end
      default: ;
    endcase
  end

  // Control FSM, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                op_q  <= op;
                a_q   <= A;
                b_q   <= B;
                cnt   <= CNT_W'(MULT_CYCLES);
                busy  <= 1'b1;
                state <= S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                op_q  <= op;
                a_q   <= A;
                b_q   <= B;
                cnt   <= CNT_W'(DIV_CYCLES);
                busy  <= 1'b1;
                state <= S_RUN;
              end
              OP_MTHI: hi <= A;
              OP_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // The edge that takes the counter to zero ends the window and commits.
          if (cnt <= CNT_W'(1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
            if (res_we) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_stall_source.sv
// Self-checking bench for mdu_stall_source: directed cases plus random ops,
// compared against a 64-bit arithmetic reference model of HI/LO.
module tb_mdu_stall_source;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int errors;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_stall_source #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what HI/LO become after op, and how many busy cycles it takes.
  task automatic model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic [31:0] nh, output logic [31:0] nl);
    int              sa32, sb32;
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa32 = a;  sb32 = b;
    sa = sa32; sb = sb32;
    ua = a;    ub = b;
    nh = m_hi; nl = m_lo; n = 0;
    case (mop)
      3'd0: begin sp = sa * sb; nh = sp[63:32]; nl = sp[31:0]; n = MULT_N; end
      3'd1: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; n = MULT_N; end
      3'd2: begin
        n = DIV_N;
        if (b != 0) begin sq = sa / sb; sr = sa % sb; nl = sq[31:0]; nh = sr[31:0]; end
      end
      3'd3: begin
        n = DIV_N;
        if (b != 0) begin uq = ua / ub; ur = ua % ub; nl = uq[31:0]; nh = ur[31:0]; end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
  endtask

  // Issue one op, optionally pulse a second request at busy cycle inj_at,
  // scramble A/B while busy, then check busy length and final HI/LO.
  task automatic run_op(input string tag, input logic [2:0] mop, input logic [31:0] a,
                        input logic [31:0] b, input int inj_at, input logic [2:0] inj_op);
    int          n, exp_n;
    logic [31:0] nh, nl;
    model(mop, a, b, exp_n, nh, nl);
    @(negedge clk);
    start = 1'b1; op = mop; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      check({tag, "_hold_hi"}, hi, m_hi);
      check({tag, "_hold_lo"}, lo, m_lo);
      if (n == inj_at) begin
        start = 1'b1; op = inj_op; A = $urandom | 32'h1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      B = $urandom;
    end
    start = 1'b0;
    check({tag, "_busy_len"}, 32'(n), 32'(exp_n));
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    m_hi = nh; m_lo = nl;
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    vectors = 0; errors = 0;
    m_hi = '0; m_lo = '0;
    start = 1'b0; op = 3'd7; A = '0; B = '0;
    reset = 1'b0;

    // Reset state.
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // First start accepted on the first edge after release.
    start = 1'b1; op = 3'd4; A = 32'h5555AAAA;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_hi = 32'h5555AAAA;
    check("first_mthi_hi", hi, 32'h5555AAAA);
    check("first_mthi_lo", lo, 32'd0);

    // Directed arithmetic cases with fixed expected values.
    run_op("mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3, -1, 3'd7);
    check("mult_neg_hi_k", hi, 32'hFFFFFFFF);
    check("mult_neg_lo_k", lo, 32'hFFFFFFFA);

    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 3'd7);
    check("multu_max_hi_k", hi, 32'hFFFFFFFE);
    check("multu_max_lo_k", lo, 32'h00000001);

    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, -1, 3'd7);
    check("div_neg_hi_k", hi, 32'hFFFFFFFF);
    check("div_neg_lo_k", lo, 32'hFFFFFFFD);

    run_op("divu_zero", 3'd3, 32'd7, 32'd0, -1, 3'd7);
    check("divu_zero_hi_k", hi, 32'hFFFFFFFF);
    check("divu_zero_lo_k", lo, 32'hFFFFFFFD);

    run_op("divu_mthi", 3'd3, 32'd100, 32'd7, 3, 3'd4);
    check("divu_mthi_hi_k", hi, 32'd2);
    check("divu_mthi_lo_k", lo, 32'd14);

    run_op("mtlo", 3'd5, 32'hCAFEBABE, 32'd0, -1, 3'd7);
    check("mtlo_lo_k", lo, 32'hCAFEBABE);
    check("mtlo_hi_k", hi, 32'd2);

    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, -1, 3'd7);
    check("div_ovf_hi_k", hi, 32'h00000000);
    check("div_ovf_lo_k", lo, 32'h80000000);

    run_op("div_zero", 3'd2, 32'h12345678, 32'd0, 9, 3'd5);
    run_op("nop6", 3'd6, 32'hDEADBEEF, 32'd1, -1, 3'd7);
    run_op("nop7", 3'd7, 32'hDEADBEEF, 32'd1, -1, 3'd7);
    run_op("mult_inj_last", 3'd0, 32'h7FFFFFFF, 32'h80000000, MULT_N - 1, 3'd0);

    // Randomized ops, including zero divisors and stray requests while busy.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop, iop;
      logic [31:0] ra, rb;
      int          at;
      rop = 3'($urandom_range(0, 7));
      iop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      at  = $urandom_range(0, 12);
      run_op("rand", rop, ra, rb, at, iop);
    end

    // Reset mid-operation aborts it asynchronously and nothing is written later.
    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'h01234567; B = 32'h89ABCDEF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_hi", hi, 32'd0);
      check("post_rst_lo", lo, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mdu_stall_source.md
MDU_STALL_SOURCE -- requirements
Module: mdu_stall_source

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, number of busy cycles for DIV/DIVU.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  one-cycle request to begin the operation given by op.
REQ-006 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
REQ-007 A  input  32  operand rs (multiplicand/dividend/MT source).
REQ-008 B  input  32  operand rt (multiplier/divisor).
REQ-009 busy  output  1  registered; high while an arithmetic operation is in flight; the hazard unit uses it to deassert the D-stage register WE.
REQ-010 hi  output  32  registered HI register value.
REQ-011 lo  output  32  registered LO register value.

Function
REQ-012 Idle (busy=0) + start + op in {0..3}: latch A, B, op on that edge; busy=1 after the edge; counter loaded with MULT_CYCLES or DIV_CYCLES.
REQ-013 Counter decrements once per edge while busy; on the edge where it reaches 0, hi/lo take the result and busy returns to 0, so busy is high for exactly N cycles.
REQ-014 hi/lo hold old values throughout the busy window; new values visible the cycle after busy falls.
REQ-015 start while busy=1: ignored entirely (no relatch, no restart, no MT write).
REQ-016 MTHI/MTLO with start, busy=0: hi (resp. lo) <= A on that edge; busy stays 0; the other register unchanged.
REQ-017 op 6/7 with start: no state change.
REQ-018 MULT: {hi,lo} = signed 32x32 -> 64-bit product; MULTU: unsigned product.
REQ-019 DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-020 Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
REQ-021 Divisor 0 (DIV or DIVU): full busy window still elapses; hi and lo remain unchanged.
REQ-022 Operands are taken only from the latched copies; A/B changing during busy has no effect.
REQ-023 Two states only: IDLE (busy=0) and RUN (busy=1); IDLE->RUN on REQ-012, RUN->IDLE on counter reaching 0; no other transitions except reset.

Reset
REQ-024 reset=0 forces immediately, independent of clk: busy=0, hi=0, lo=0, counter=0, latched operands=0, state IDLE.
REQ-025 reset asserted mid-operation aborts it; no result is written after reset release.
REQ-026 First start accepted on the first rising edge with reset=1.

Verification
REQ-027 MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-028 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU A=7, B=0 -> hi/lo unchanged after 10 cycles.
REQ-030 DIVU A=100, B=7 started, start MTHI A=0x1234 pulsed during busy -> MTHI ignored; final lo=14, hi=2.
REQ-031 MTLO A=0xCAFEBABE at idle -> lo=0xCAFEBABE next cycle, busy stays 0, hi unchanged.
REQ-032 MULT started, reset=0 on cycle 3 -> busy, hi, lo are 0 immediately and stay 0 after release with no further start.
